keccak_obi_bridge: RTL and testbench

//  OBI slave that sits on external-xbar slave port KECCAK_IDX, directly upstream of the Keccak-f[1600] core.

---
 rtl/keccak_obi_bridge.sv | 144 ++++++++++++++
 tb/tb_keccak_obi_bridge.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_obi_bridge.sv
// OBI slave bridge for the Keccak-f[1600] core: stages the input state,
// launches the permutation, buffers the result and counts run cycles.
module keccak_obi_bridge #(
  parameter int NUM_WORDS = 50,
  parameter int OFF_W     = 10,
  parameter int CNT_W     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [31:0]             addr_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [31:0]             wdata_i,
  output logic                    rvalid_o,
  output logic [31:0]             rdata_o,
  output logic [NUM_WORDS*32-1:0] din_o,
  output logic                    start_o,
  input  logic [NUM_WORDS*32-1:0] dout_i,
  input  logic                    done_i,
  output logic                    irq_o
);
  localparam int AW = $clog2(NUM_WORDS);
  localparam logic [31:0] NW     = 32'(NUM_WORDS);
  localparam logic [31:0] DOUT_W = 32'h40;
  localparam logic [31:0] CTRL_W = 32'h80;
  localparam logic [31:0] STAT_W = 32'h81;
  localparam logic [31:0] CYC_W  = 32'h82;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [31:0]      r_din  [NUM_WORDS];
  logic [31:0]      r_dout [NUM_WORDS];
  logic [CNT_W-1:0] r_cnt;
  logic             r_irq_en;
  logic             r_start;
  logic             r_irq;
  logic             r_rvalid;
  logic [31:0]      r_rdata;

  logic [31:0] w_word;
  logic [31:0] w_doff;
  logic [31:0] w_mask;
  logic [31:0] w_rdata;
  logic        w_wr;
  logic        w_din_hit;
  logic        w_dout_hit;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_clr;

  assign w_word     = 32'(addr_i[OFF_W-1:2]);
  assign w_doff     = w_word - DOUT_W;
  assign w_din_hit  = w_word < NW;
  assign w_dout_hit = (w_word >= DOUT_W) && (w_doff < NW);
  assign w_wr       = req_i && we_i;
  assign w_mask     = {{8{be_i[3]}}, {8{be_i[2]}},
                       {8{be_i[1]}}, {8{be_i[0]}}};
  // Control bits all live in byte 0.
  assign w_ctrl_wr  = w_wr && (w_word == CTRL_W) && be_i[0];
  assign w_start    = w_ctrl_wr && wdata_i[0];
  assign w_clr      = w_ctrl_wr && wdata_i[1];

  assign gnt_o    = req_i;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign start_o  = r_start;
  assign irq_o    = r_irq;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_din
    assign din_o[32*k +: 32] = r_din[k];
  end

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_din_hit:            w_rdata = r_din[w_word[AW-1:0]];
      w_dout_hit:           w_rdata = r_dout[w_doff[AW-1:0]];
      (w_word == CTRL_W):   w_rdata = {29'd0, r_irq_en, 2'd0};
      (w_word == STAT_W):   w_rdata = {30'd0, r_state == S_DONE,
                                       r_state == S_RUN};
      (w_word == CYC_W):    w_rdata = 32'(r_cnt);
      default:              w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_irq_en <= 1'b0;
      r_start  <= 1'b0;
      r_irq    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_start  <= 1'b0;
      r_rvalid <= req_i;
      r_rdata  <= (req_i && !we_i) ? w_rdata : '0;
      r_irq    <= (r_state == S_DONE) && r_irq_en;
      if (w_ctrl_wr) r_irq_en <= wdata_i[2];
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_start <= 1'b1;
            r_cnt   <= '0;
          end else if (w_clr) begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (done_i) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // State buffers: DIN frozen while the core runs, DOUT loads on completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        r_din[k]  <= '0;
        r_dout[k] <= '0;
      end
    end else begin
      if (w_wr && w_din_hit && (r_state != S_RUN))
        r_din[w_word[AW-1:0]] <= (r_din[w_word[AW-1:0]] & ~w_mask)
                               | (wdata_i & w_mask);
      if ((r_state == S_RUN) && done_i)
        for (int k = 0; k < NUM_WORDS; k++)
          r_dout[k] <= dout_i[32*k +: 32];
    end
  end

endmodule

// File: tb/tb_keccak_obi_bridge.sv
// Self-checking bench for keccak_obi_bridge: scoreboarded OBI transactions
// plus direct checks on start/irq/din sideband signals.
module tb_keccak_obi_bridge;
  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_i;
  logic          gnt_o;
  logic [31:0]   addr_i;
  logic          we_i;
  logic [3:0]    be_i;
  logic [31:0]   wdata_i;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic [1599:0] din_o;
  logic          start_o;
  logic [1599:0] dout_i;
  logic          done_i;
  logic          irq_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  keccak_obi_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .din_o(din_o),
    .start_o(start_o), .dout_i(dout_i), .done_i(done_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rvalid_o) obs_q.push_back(rdata_o);
  endtask

  task automatic bus(input bit we, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd,
                     input logic [31:0] e);
    req_i = 1'b1; we_i = we; addr_i = a; be_i = be; wdata_i = wd;
    exp_q.push_back(we ? 32'h0 : e);
    tick();
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; wdata_i = '0;
  endtask

  function automatic logic [32:0] pop_obs();
    if (obs_q.size() == 0) return {1'b0, 32'hDEADDEAD};
    return {1'b1, obs_q.pop_front()};
  endfunction

  task automatic test_reset();
    logic [32:0] r;
    logic [31:0] e;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0;
    be_i = '0; wdata_i = '0; dout_i = '0; done_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    n_tests++;
    if ({rvalid_o, start_o, irq_o, gnt_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b exp 0000",
               {rvalid_o, start_o, irq_o, gnt_o});
    end
    n_tests++;
    if (din_o !== '0 || rdata_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: din nonzero=%0b rdata=%h exp 0",
               din_o != '0, rdata_o);
    end
    bus(0, 32'h204, 4'hF, 0, 32'h0);
    bus(0, 32'h208, 4'hF, 0, 32'h0);
    bus(0, 32'h1C4, 4'hF, 0, 32'h0);
    while (exp_q.size() > 0) begin
      r = pop_obs(); e = exp_q.pop_front(); n_tests++;
      if (r !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL reset_rd: got %h exp %h", r, {1'b1, e});
      end
    end
  endtask

  task automatic test_byte_write();
    logic [32:0] r;
    logic [31:0] e;
    bus(1, 32'h000, 4'b0011, 32'hDEADBEEF, 0);
    bus(0, 32'h000, 4'hF, 0, 32'h0000BEEF);
    n_tests++;
    if (din_o[15:0] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL din_o_lo: got %h exp beef", din_o[15:0]);
    end
    bus(1, 32'h000, 4'b0000, 32'hFFFFFFFF, 0);
    bus(0, 32'h000, 4'hF, 0, 32'h0000BEEF);
    bus(1, 32'h000, 4'b1000, 32'hAB123456, 0);
    bus(0, 32'h000, 4'hF, 0, 32'hAB00BEEF);
    bus(1, 32'h0C4, 4'hF, 32'h01020304, 0);
    bus(0, 32'h0C4, 4'hF, 0, 32'h01020304);
    n_tests++;
    if (din_o[49*32 +: 32] !== 32'h01020304) begin
      n_fail++;
      $display("FAIL din_o_w49: got %h exp 01020304", din_o[49*32 +: 32]);
    end
    while (exp_q.size() > 0) begin
      r = pop_obs(); e = exp_q.pop_front(); n_tests++;
      if (r !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL byte_rd: got %h exp %h", r, {1'b1, e});
      end
    end
  endtask

  task automatic test_run();
    logic [32:0] r;
    logic [31:0] e;
    dout_i = '0;
    dout_i[49*32 +: 32] = 32'h12345678;
    dout_i[31:0] = 32'h0BADCAFE;
    bus(1, 32'h200, 4'hF, 32'h1, 0);
    n_tests++;
    if (start_o !== 1'b1) begin
      n_fail++;
      $display("FAIL start_hi: got %b exp 1", start_o);
    end
    tick();
    n_tests++;
    if (start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start_pulse: got %b exp 0", start_o);
    end
    bus(0, 32'h204, 4'hF, 0, 32'h1);
    repeat (21) tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    bus(0, 32'h204, 4'hF, 0, 32'h2);
    bus(0, 32'h208, 4'hF, 0, 32'd24);
    bus(0, 32'h1C4, 4'hF, 0, 32'h12345678);
    bus(0, 32'h100, 4'hF, 0, 32'h0BADCAFE);
    n_tests++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_dis: got %b exp 0", irq_o);
    end
    bus(1, 32'h200, 4'hF, 32'h4, 0);
    repeat (3) begin
      tick();
      n_tests++;
      if (irq_o !== 1'b1) begin
        n_fail++;
        $display("FAIL irq_on: got %b exp 1", irq_o);
      end
    end
    bus(1, 32'h200, 4'hF, 32'h6, 0);
    tick();
    n_tests++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clr: got %b exp 0", irq_o);
    end
    bus(0, 32'h204, 4'hF, 0, 32'h0);
    bus(0, 32'h200, 4'hF, 0, 32'h4);
    while (exp_q.size() > 0) begin
      r = pop_obs(); e = exp_q.pop_front(); n_tests++;
      if (r !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL run_rd: got %h exp %h", r, {1'b1, e});
      end
    end
  endtask

  task automatic test_run_protect();
    logic [32:0] r;
    logic [31:0] e;
    bus(1, 32'h00C, 4'hF, 32'h11111111, 0);
    bus(1, 32'h200, 4'hF, 32'h1, 0);
    dout_i[49*32 +: 32] = 32'hCAFEF00D;
    tick();
    bus(1, 32'h00C, 4'hF, 32'hFFFFFFFF, 0);
    bus(1, 32'h200, 4'hF, 32'h1, 0);
    n_tests++;
    if (start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_run: got %b exp 0", start_o);
    end
    bus(0, 32'h00C, 4'hF, 0, 32'h11111111);
    bus(0, 32'h1C4, 4'hF, 0, 32'h12345678);
    n_tests++;
    if (din_o[3*32 +: 32] !== 32'h11111111) begin
      n_fail++;
      $display("FAIL din_stable: got %h exp 11111111", din_o[3*32 +: 32]);
    end
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    bus(0, 32'h1C4, 4'hF, 0, 32'hCAFEF00D);
    bus(0, 32'h204, 4'hF, 0, 32'h2);
    bus(1, 32'h200, 4'hF, 32'h3, 0);
    n_tests++;
    if (start_o !== 1'b1) begin
      n_fail++;
      $display("FAIL start_wins: got %b exp 1", start_o);
    end
    bus(0, 32'h204, 4'hF, 0, 32'h1);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    bus(1, 32'h200, 4'hF, 32'h2, 0);
    bus(0, 32'h204, 4'hF, 0, 32'h0);
    dout_i[49*32 +: 32] = 32'h55555555;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    bus(0, 32'h204, 4'hF, 0, 32'h0);
    bus(0, 32'h1C4, 4'hF, 0, 32'hCAFEF00D);
    while (exp_q.size() > 0) begin
      r = pop_obs(); e = exp_q.pop_front(); n_tests++;
      if (r !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL protect_rd: got %h exp %h", r, {1'b1, e});
      end
    end
  endtask

  task automatic test_unmapped();
    logic [32:0] r;
    logic [31:0] e;
    bus(0, 32'h3F0, 4'hF, 0, 32'h0);
    n_tests++;
    if (rvalid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rvalid_rd: got %b exp 1", rvalid_o);
    end
    tick();
    n_tests++;
    if (rvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rvalid_once: got %b exp 0", rvalid_o);
    end
    bus(1, 32'h3F0, 4'hF, 32'hFFFFFFFF, 0);
    n_tests++;
    if (rvalid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rvalid_wr: got %b exp 1", rvalid_o);
    end
    bus(1, 32'h0C8, 4'hF, 32'hFFFFFFFF, 0);
    bus(0, 32'h0C8, 4'hF, 0, 32'h0);
    bus(0, 32'h3F0, 4'hF, 0, 32'h0);
    bus(0, 32'h204, 4'hF, 0, 32'h0);
    bus(0, 32'h200, 4'hF, 0, 32'h0);
    bus(0, 32'h000, 4'hF, 0, 32'hAB00BEEF);
    bus(0, 32'h0C4, 4'hF, 0, 32'h01020304);
    while (exp_q.size() > 0) begin
      r = pop_obs(); e = exp_q.pop_front(); n_tests++;
      if (r !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL unmapped_rd: got %h exp %h", r, {1'b1, e});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] r;
    logic [31:0] e;
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      bit wr;
      wr = (i < 4);
      v = 32'hA0000000 | (32'(i % 4) * 32'h01010101);
      req_i = 1'b1; we_i = wr; be_i = 4'hF;
      addr_i = 32'(10 + (i % 4)) << 2;
      wdata_i = v;
      exp_q.push_back(wr ? 32'h0 : v);
      #1;
      n_tests++;
      if (gnt_o !== 1'b1) begin
        n_fail++;
        $display("FAIL gnt_b2b: got %b exp 1", gnt_o);
      end
      @(posedge clk_i);
      #1;
      if (rvalid_o) obs_q.push_back(rdata_o);
    end
    req_i = 1'b0; we_i = 1'b0; be_i = '0;
    #1;
    n_tests++;
    if (gnt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL gnt_idle: got %b exp 0", gnt_o);
    end
    tick();
    n_tests++;
    if (obs_q.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d exp 8", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      r = pop_obs(); e = exp_q.pop_front(); n_tests++;
      if (r !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL b2b_rd: got %h exp %h", r, {1'b1, e});
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [32:0] r;
    logic [31:0] e;
    bus(1, 32'h200, 4'hF, 32'h4, 0);
    bus(1, 32'h200, 4'hF, 32'h5, 0);
    repeat (4) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_tests++;
    if (din_o !== '0 || irq_o !== 1'b0 || start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: din nonzero=%0b irq=%b start=%b exp 0",
               din_o != '0, irq_o, start_o);
    end
    exp_q.delete();
    obs_q.delete();
    bus(0, 32'h204, 4'hF, 0, 32'h0);
    bus(0, 32'h200, 4'hF, 0, 32'h0);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
    bus(0, 32'h204, 4'hF, 0, 32'h0);
    bus(0, 32'h1C4, 4'hF, 0, 32'h0);
    n_tests++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_after_rst: got %b exp 0", irq_o);
    end
    while (exp_q.size() > 0) begin
      r = pop_obs(); e = exp_q.pop_front(); n_tests++;
      if (r !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL mid_reset_rd: got %h exp %h", r, {1'b1, e});
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_run();
    test_run_protect();
    test_unmapped();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
